// File: rtl/rng_burst_packer.sv
// Buffers entropy bytes in a small FIFO and sends them to a UART as packets:
// HEADER, BURST_LEN, BURST_LEN data bytes, XOR checksum of the data bytes.
module rng_burst_packer #(
  parameter int         FIFO_DEPTH = 16,
  parameter int         BURST_LEN  = 8,
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter bit         CONT_MODE  = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        trig,
  input  logic                        rnd_Valid,
  input  logic [7:0]                  rnd_Byte,
  output logic                        rnd_Ready,
  output logic                        tx_Start,
  output logic [7:0]                  tx_Data,
  input  logic                        tx_Done,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_Count
);

  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam int             CW      = AW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [7:0]     LEN_C   = 8'(BURST_LEN);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_STALL} state_t;
  typedef enum logic [1:0] {FLD_HDR, FLD_LEN, FLD_DATA, FLD_CSUM} field_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q, count_d;

  state_t     state_q;
  field_t     field_q;
  logic [7:0] dataIdx_q;
  logic [7:0] csum_q;
  logic [7:0] txData_q;
  logic       txStart_q;
  logic       busy_q;
  logic       overflow_q;

  logic       push;
  logic       pop;
  logic [7:0] head;
  logic       doneInWait;
  logic       lastData;
  logic       nextIsData;

  assign rnd_Ready  = (count_q != DEPTH_C);
  assign push       = rnd_Valid & rnd_Ready;
  assign head       = mem_q[rdPtr_q];
  assign fifo_Count = count_q;
  assign tx_Start   = txStart_q;
  assign tx_Data    = txData_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;

  // A pop happens whenever the FSM is about to emit a data byte and one is held.
  always_comb begin
    doneInWait = (state_q == ST_WAIT) & tx_Done;
    lastData   = ((dataIdx_q + 8'd1) == LEN_C);
    nextIsData = (field_q == FLD_LEN) | ((field_q == FLD_DATA) & ~lastData);
    pop        = (count_q != '0) & ((state_q == ST_STALL) | (doneInWait & nextIsData));
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= rnd_Byte;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      field_q    <= FLD_HDR;
      dataIdx_q  <= '0;
      csum_q     <= '0;
      txData_q   <= '0;
      txStart_q  <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      txStart_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (trig) begin
            state_q    <= ST_SEND;
            field_q    <= FLD_HDR;
            dataIdx_q  <= '0;
            csum_q     <= '0;
            txData_q   <= HEADER;
            txStart_q  <= 1'b1;
            busy_q     <= 1'b1;
            overflow_q <= 1'b0;
          end
        end
        ST_SEND: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (tx_Done) begin
            case (field_q)
              FLD_HDR: begin
                field_q   <= FLD_LEN;
                txData_q  <= LEN_C;
                txStart_q <= 1'b1;
                state_q   <= ST_SEND;
              end
              FLD_LEN: begin
                field_q   <= FLD_DATA;
                dataIdx_q <= '0;
                state_q   <= ST_STALL;
              end
              FLD_DATA: begin
                if (lastData) begin
                  field_q   <= FLD_CSUM;
                  txData_q  <= csum_q;
                  txStart_q <= 1'b1;
                  state_q   <= ST_SEND;
                end else begin
                  dataIdx_q <= dataIdx_q + 8'd1;
                  state_q   <= ST_STALL;
                end
              end
              FLD_CSUM: begin
                if (CONT_MODE) begin
                  field_q    <= FLD_HDR;
                  dataIdx_q  <= '0;
                  csum_q     <= '0;
                  txData_q   <= HEADER;
                  txStart_q  <= 1'b1;
                  overflow_q <= 1'b0;
                  state_q    <= ST_SEND;
                end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                end
              end
            endcase
          end
        end
        ST_STALL: ;
      endcase
      // A data byte entering the pipeline overrides the STALL chosen above.
      if (pop) begin
        txData_q  <= head;
        csum_q    <= csum_q ^ head;
        txStart_q <= 1'b1;
        state_q   <= ST_SEND;
      end
      if (rnd_Valid && !rnd_Ready) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rng_burst_packer.sv
// Self-checking bench: a default-parameter instance and a continuous-mode
// instance (BURST_LEN=2), each served by a small UART responder model.
module tb_rng_burst_packer;

  localparam logic [7:0] HDR = 8'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       resetA = 1'b0, trigA = 1'b0, rnd_ValidA = 1'b0, tx_DoneA;
  logic [7:0] rnd_ByteA = 8'h00;
  logic       rnd_ReadyA, tx_StartA, busyA, overflowA;
  logic [7:0] tx_DataA;
  logic [4:0] fifo_CountA;

  logic       resetC = 1'b0, trigC = 1'b0, rnd_ValidC = 1'b0, tx_DoneC;
  logic [7:0] rnd_ByteC = 8'h00;
  logic       rnd_ReadyC, tx_StartC, busyC, overflowC;
  logic [7:0] tx_DataC;
  logic [4:0] fifo_CountC;

  rng_burst_packer dut (
    .clk(clk), .reset(resetA), .trig(trigA), .rnd_Valid(rnd_ValidA), .rnd_Byte(rnd_ByteA),
    .rnd_Ready(rnd_ReadyA), .tx_Start(tx_StartA), .tx_Data(tx_DataA), .tx_Done(tx_DoneA),
    .busy(busyA), .overflow(overflowA), .fifo_Count(fifo_CountA)
  );

  rng_burst_packer #(.BURST_LEN(2), .CONT_MODE(1'b1)) dutC (
    .clk(clk), .reset(resetC), .trig(trigC), .rnd_Valid(rnd_ValidC), .rnd_Byte(rnd_ByteC),
    .rnd_Ready(rnd_ReadyC), .tx_Start(tx_StartC), .tx_Data(tx_DataC), .tx_Done(tx_DoneC),
    .busy(busyC), .overflow(overflowC), .fifo_Count(fifo_CountC)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] modelA[$];
  logic [7:0] expA[$];
  logic [7:0] rxA[$];
  logic [7:0] rxC[$];
  logic [7:0] streamC[$];

  int respDelayA  = 2;
  bit respRandA   = 1'b0;
  bit strictLatA  = 1'b0;
  int lastDoneA   = -1;

  typedef struct {
    int nPush;
    int expCount;
    int expReady;
    int expOvf;
  } fillVec_t;
  fillVec_t fillTab[4];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d expected %0d", name, actual, expected);
    end
  endtask

  // UART model for instance A: records each byte and answers with tx_Done.
  initial begin
    int cnt;
    bit pend;
    pend = 1'b0;
    cnt = 0;
    tx_DoneA = 1'b0;
    forever begin
      @(negedge clk);
      tx_DoneA = 1'b0;
      if (!resetA) begin
        pend = 1'b0;
      end else if (tx_StartA) begin
        rxA.push_back(tx_DataA);
        if (strictLatA && lastDoneA >= 0) checkOutput("latencyA", cyc - lastDoneA, 1);
        cnt  = respRandA ? int'($urandom_range(1, 4)) : respDelayA;
        pend = 1'b1;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          tx_DoneA  = 1'b1;
          pend      = 1'b0;
          lastDoneA = cyc;
        end
      end
    end
  end

  initial begin
    int cnt;
    bit pend;
    pend = 1'b0;
    cnt = 0;
    tx_DoneC = 1'b0;
    forever begin
      @(negedge clk);
      tx_DoneC = 1'b0;
      if (!resetC) begin
        pend = 1'b0;
      end else if (tx_StartC) begin
        rxC.push_back(tx_DataC);
        cnt  = 2;
        pend = 1'b1;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          tx_DoneC = 1'b1;
          pend     = 1'b0;
        end
      end
    end
  end

  // Offers n bytes on consecutive cycles; the model keeps what a 16-deep buffer accepts.
  task automatic applyStimulus(input int n, input int startVal);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b = (startVal < 0) ? 8'($urandom) : 8'(startVal + i);
      rnd_ValidA = 1'b1;
      rnd_ByteA  = b;
      if (modelA.size() < 16) modelA.push_back(b);
    end
    @(negedge clk);
    rnd_ValidA = 1'b0;
  endtask

  task automatic resetPulseA();
    @(negedge clk);
    resetA = 1'b0;
    trigA = 1'b0;
    rnd_ValidA = 1'b0;
    repeat (2) @(negedge clk);
    resetA = 1'b1;
    modelA.delete();
    rxA.delete();
  endtask

  task automatic pulseTrigA();
    @(negedge clk);
    trigA = 1'b1;
    @(negedge clk);
    trigA = 1'b0;
  endtask

  task automatic waitIdleA(input int maxCyc, input string name);
    int n;
    n = 0;
    while (busyA && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, int'(busyA), 0);
  endtask

  task automatic buildExpA(input int len);
    logic [7:0] x;
    logic [7:0] b;
    expA.delete();
    expA.push_back(HDR);
    expA.push_back(8'(len));
    x = 8'h00;
    for (int i = 0; i < len; i++) begin
      b = (modelA.size() > 0) ? modelA.pop_front() : 8'h00;
      expA.push_back(b);
      x ^= b;
    end
    expA.push_back(x);
  endtask

  task automatic checkPacketA(input string name);
    int n;
    checkOutput({name, "_len"}, rxA.size(), expA.size());
    n = (rxA.size() < expA.size()) ? rxA.size() : expA.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s[%0d]", name, i), int'(rxA[i]), int'(expA[i]));
    rxA.delete();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int t0;
    fillTab[0] = '{nPush: 0,  expCount: 0,  expReady: 1, expOvf: 0};
    fillTab[1] = '{nPush: 5,  expCount: 5,  expReady: 1, expOvf: 0};
    fillTab[2] = '{nPush: 11, expCount: 16, expReady: 0, expOvf: 0};
    fillTab[3] = '{nPush: 1,  expCount: 16, expReady: 0, expOvf: 1};

    repeat (3) @(negedge clk);
    checkOutput("rstTxStart", int'(tx_StartA), 0);
    checkOutput("rstTxData", int'(tx_DataA), 0);
    checkOutput("rstBusy", int'(busyA), 0);
    checkOutput("rstOverflow", int'(overflowA), 0);
    checkOutput("rstCount", int'(fifo_CountA), 0);
    checkOutput("rstReady", int'(rnd_ReadyA), 1);
    resetA = 1'b1;

    $display("[TB] basic packet 01..08");
    applyStimulus(8, 1);
    checkOutput("basicCount", int'(fifo_CountA), 8);
    lastDoneA  = -1;
    strictLatA = 1'b1;
    pulseTrigA();
    checkOutput("basicStartHdr", int'(tx_DataA), int'(HDR));
    waitIdleA(300, "basicIdle");
    strictLatA = 1'b0;
    buildExpA(8);
    checkOutput("basicCsum", int'(expA[10]), 'h08);
    checkPacketA("basicPkt");

    $display("[TB] stall on empty buffer");
    resetPulseA();
    pulseTrigA();
    repeat (20) @(negedge clk);
    checkOutput("stallRxCount", rxA.size(), 2);
    checkOutput("stallBusy", int'(busyA), 1);
    checkOutput("stallNoStart", int'(tx_StartA), 0);
    @(negedge clk);
    rnd_ValidA = 1'b1;
    rnd_ByteA  = 8'h3C;
    modelA.push_back(8'h3C);
    t0 = cyc;
    @(negedge clk);
    rnd_ValidA = 1'b0;
    n = 0;
    while (!tx_StartA && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stallResumeStart", int'(tx_StartA), 1);
    checkOutput("stallResumeGap", cyc - t0, 2);
    checkOutput("stallResumeData", int'(tx_DataA), 'h3C);
    applyStimulus(7, -1);
    waitIdleA(400, "stallIdle");
    buildExpA(8);
    checkPacketA("stallPkt");

    $display("[TB] buffer fill and overflow table");
    resetPulseA();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(fillTab[i].nPush, -1);
      checkOutput($sformatf("fillCount%0d", i), int'(fifo_CountA), fillTab[i].expCount);
      checkOutput($sformatf("fillReady%0d", i), int'(rnd_ReadyA), fillTab[i].expReady);
      checkOutput($sformatf("fillOvf%0d", i), int'(overflowA), fillTab[i].expOvf);
    end
    pulseTrigA();
    checkOutput("trigOvfClear", int'(overflowA), 0);
    checkOutput("trigBusy", int'(busyA), 1);
    checkOutput("trigTxStart", int'(tx_StartA), 1);
    waitIdleA(300, "fillIdle");
    buildExpA(8);
    checkPacketA("fillPkt");
    checkOutput("fillLeft", int'(fifo_CountA), 8);

    $display("[TB] randomized packets");
    resetPulseA();
    respRandA = 1'b1;
    for (int p = 0; p < 6; p++) begin
      int pushesLeft;
      int trigAt;
      bit finished;
      pushesLeft = 8;
      trigAt = int'($urandom_range(0, 10));
      finished = 1'b0;
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        trigA = 1'b0;
        rnd_ValidA = 1'b0;
        if (c > trigAt + 1 && !busyA && pushesLeft == 0) begin
          finished = 1'b1;
          break;
        end
        if (c == trigAt) trigA = 1'b1;
        else if (c > trigAt && busyA && $urandom_range(0, 15) == 0) trigA = 1'b1;
        if (pushesLeft > 0 && $urandom_range(0, 3) == 0) begin
          rnd_ValidA = 1'b1;
          rnd_ByteA  = 8'($urandom);
          modelA.push_back(rnd_ByteA);
          pushesLeft--;
        end
      end
      checkOutput($sformatf("rndDone%0d", p), int'(finished), 1);
      buildExpA(8);
      checkPacketA($sformatf("rndPkt%0d", p));
      checkOutput($sformatf("rndEmpty%0d", p), int'(fifo_CountA), 0);
    end
    respRandA = 1'b0;

    $display("[TB] reset during data byte 3");
    resetPulseA();
    respDelayA = 3;
    applyStimulus(8, -1);
    pulseTrigA();
    n = 0;
    while (rxA.size() < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midRxCount", rxA.size(), 5);
    @(negedge clk);
    resetA = 1'b0;
    #1;
    checkOutput("midRstTxStart", int'(tx_StartA), 0);
    checkOutput("midRstTxData", int'(tx_DataA), 0);
    checkOutput("midRstBusy", int'(busyA), 0);
    checkOutput("midRstOvf", int'(overflowA), 0);
    checkOutput("midRstCount", int'(fifo_CountA), 0);
    checkOutput("midRstReady", int'(rnd_ReadyA), 1);
    repeat (2) @(negedge clk);
    resetA = 1'b1;
    modelA.delete();
    rxA.delete();
    repeat (6) @(negedge clk);
    checkOutput("midNoResume", rxA.size(), 0);
    applyStimulus(8, -1);
    pulseTrigA();
    waitIdleA(400, "midIdle");
    buildExpA(8);
    checkPacketA("midRestartPkt");

    $display("[TB] continuous mode");
    @(negedge clk);
    resetC = 1'b1;
    @(negedge clk);
    trigC = 1'b1;
    rnd_ValidC = 1'b1;
    rnd_ByteC = 8'($urandom);
    streamC.push_back(rnd_ByteC);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      trigC = 1'b0;
      rnd_ByteC = 8'($urandom);
      streamC.push_back(rnd_ByteC);
    end
    checkOutput("contBusy", int'(busyC), 1);
    n = rxC.size() / 5;
    checkOutput("contEnough", int'(n >= 10), 1);
    if (rxC.size() >= 5) begin
      checkOutput("contFirstD0", int'(rxC[2]), int'(streamC[0]));
      checkOutput("contFirstD1", int'(rxC[3]), int'(streamC[1]));
    end
    begin
      int sp;
      sp = 0;
      for (int k = 0; k < n; k++) begin
        checkOutput($sformatf("contHdr%0d", k), int'(rxC[5*k]), int'(HDR));
        checkOutput($sformatf("contLen%0d", k), int'(rxC[5*k+1]), 2);
        checkOutput($sformatf("contCsum%0d", k), int'(rxC[5*k+4]), int'(rxC[5*k+2] ^ rxC[5*k+3]));
        for (int j = 2; j < 4; j++) begin
          while (sp < streamC.size() && streamC[sp] != rxC[5*k+j]) sp++;
          checkOutput($sformatf("contOrder%0d_%0d", k, j), int'(sp < streamC.size()), 1);
          sp++;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
